mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- EX/MEM pipeline register plus data-memory access control. Consumes the execute stage's results (ALUOutE, WriteDataE, WriteRegE, control bits), drives a valid/ready data-memory port, and produces the MEM/WB register contents.
- Stalls the pipeline while a memory operation is outstanding.
- Feeds ALUOutM back to execute-stage forwarding, and WriteRegM/RegWriteM to the hazard unit.

Parameters:
- DATA_W, 32, datapath and memory data width.
- REG_AW, 5, register-file index width.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset; asynchronous, active-low.
- RegWriteE, MemtoRegE, MemWriteE  in  1 each  control bits from execute.
- ValidE  in  1  execute slot holds a real instruction (0 = bubble).
- ALUOutE  in  DATA_W  address or ALU result.
- WriteDataE  in  DATA_W  store data.
- WriteRegE  in  REG_AW  destination register.
- StallM  out  1  memory busy; upstream stages must hold.
- ALUOutM  out  DATA_W  forwarding source.
- WriteRegM  out  REG_AW  to hazard unit.
- RegWriteM  out  1  to hazard unit.
- dreq_valid  out  1  data-memory request valid.
- dreq_ready  in  1  data-memory request accepted.
- dreq_we  out  1  request is a store.
- dreq_addr, dreq_wdata  out  DATA_W  request address and store data.
- dresp_valid  in  1  load data valid.
- dresp_rdata  in  DATA_W  load data.
- RegWriteW, MemtoRegW  out  1 each  MEM/WB control bits.
- ALUOutW, ReadDataW  out  DATA_W  MEM/WB data.
- WriteRegW  out  REG_AW  MEM/WB destination register.

Behaviour:
- Reset: every register and output is 0 (valid bits, StallM, dreq_valid, all W outputs); FSM goes to IDLE.
- M register: loads the E inputs on each rising edge when StallM=0; holds when StallM=1.
  - ValidM = ValidE.
  - RegWriteM is gated by ValidM.
  - A memory op means ValidM & (MemtoRegM | MemWriteM).
- Request fields: dreq_addr = ALUOutM, dreq_wdata = WriteDataM, dreq_we = MemWriteM. All stay stable while dreq_valid=1.
- FSM states: IDLE, REQ, WAIT.
  - IDLE, no memory op: dreq_valid=0, StallM=0.
  - IDLE, memory op: dreq_valid=1.
    - Ready & store: the store completes; StallM=0; stay IDLE.
    - Ready & load: go to WAIT; StallM=1.
    - Not ready: go to REQ; StallM=1.
  - REQ: dreq_valid=1; StallM=1.
    - Ready & store: go to IDLE. StallM stays 1 in the accept cycle and the instruction retires next cycle. Exception: if the next M op is also a store, it is issued directly from IDLE.
    - Ready & load: go to WAIT.
  - WAIT: dreq_valid=0.
    - dresp_valid: capture dresp_rdata into ReadDataW at the edge; StallM=0 in that cycle; go to IDLE.
    - No dresp_valid: StallM=1.
- Timing: dresp_valid arrives strictly after the acceptance cycle. dresp_valid in IDLE or REQ is ignored.
- Minimum latency, load accepted immediately: 1 stall cycle; W valid 2 edges after entering M.
- Minimum latency, store accepted immediately: 0 stall cycles.
- W register:
  - Non-stalled cycle: loads RegWriteM, MemtoRegM, ALUOutM and WriteRegM. ReadDataW loads only on a load completion and otherwise holds.
  - Stalled cycle: RegWriteW and MemtoRegW are forced to 0 (bubble). The data fields hold.
- Stores never set RegWriteW.
- Reset mid-operation: FSM returns to IDLE, any outstanding request is abandoned, and a late dresp_valid is ignored.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: adds output AddrErrM (1 bit). For a memory op with ALUOutM[1:0] != 0:
  - no request is issued;
  - AddrErrM=1 for the one cycle the op occupies M;
  - StallM=0;
  - RegWriteW/MemtoRegW for that instruction are written as 0.
- Undefined: no AddrErrM port; the address goes to memory unmodified.

Decomposition:
- Shared package mips_pkg:
  - enum mem_state_t {IDLE, REQ, WAIT};
  - DATA_W/REG_AW defaults;
  - struct mem_ctrl_t {RegWrite, MemtoReg, MemWrite, Valid}.
- One sub-module, mem_req_fsm: owns the state register, dreq_valid, StallM and the completion pulse. The top level holds the M/W registers.

Test Plan:
- Load, ALUOutE=0x100: dreq_ready=1 at cycle 1, dresp_valid with 0xDEADBEEF at cycle 2 → StallM high for 1 cycle; RegWriteW=1, MemtoRegW=1, ReadDataW=0xDEADBEEF after cycle 2.
- Store to 0x200, wdata 0x55: dreq_ready=1 immediately → dreq_we=1, StallM never asserts, RegWriteW=0.
- Load with dreq_ready low for 3 cycles → dreq_valid held with addr stable; StallM=1 throughout; W bubbles (RegWriteW=0) during the stall.
- ALU op (RegWrite, no mem) followed by a load → ALUOutW/RegWriteW for the ALU op one cycle later; no request for the ALU op.
- Reset asserted in WAIT, then dresp_valid pulse after release → all outputs 0, state IDLE, response ignored.
- With MEM_ALIGN_CHECK_EN, load at 0x102 → AddrErrM=1 for 1 cycle, dreq_valid stays 0, RegWriteW=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and defaults for the EX/MEM stage and its data-memory request FSM.
package mips_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_REG_AW = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } mem_state_t;

   typedef struct packed {
      logic RegWrite;
      logic MemtoReg;
      logic MemWrite;
      logic Valid;
   } mem_ctrl_t;

endpackage

// File: rtl/mem_req_fsm.sv
// Data-memory request sequencer: drives dreq_valid and StallM, and pulses
// load_done_o in the cycle a load response is taken.
module mem_req_fsm
   import mips_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic mem_op_i,
   input  logic store_i,
   input  logic dreq_ready_i,
   input  logic dresp_valid_i,
   output logic dreq_valid_o,
   output logic stall_o,
   output logic load_done_o
);

   mem_state_t state_q, state_d;
   logic       retire_q, retire_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         retire_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         retire_q <= retire_d;
      end
   end

   // retire_q marks the cycle after a store accepted from REQ: the store is
   // still in M but must not be issued a second time.
   always_comb begin
      state_d      = state_q;
      retire_d     = 1'b0;
      dreq_valid_o = 1'b0;
      stall_o      = 1'b0;
      load_done_o  = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_op_i && !retire_q) begin
               dreq_valid_o = 1'b1;
               if (!dreq_ready_i) begin
                  state_d = REQ;
                  stall_o = 1'b1;
               end else if (!store_i) begin
                  state_d = WAIT;
                  stall_o = 1'b1;
               end
            end
         end
         REQ: begin
            dreq_valid_o = 1'b1;
            stall_o      = 1'b1;
            if (dreq_ready_i) begin
               if (store_i) begin
                  state_d  = IDLE;
                  retire_d = 1'b1;
               end else begin
                  state_d  = WAIT;
               end
            end
         end
         WAIT: begin
            if (dresp_valid_i) begin
               load_done_o = 1'b1;
               state_d     = IDLE;
            end else begin
               stall_o = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// EX/MEM and MEM/WB pipeline registers around the data-memory port.
// Optional macro MEM_ALIGN_CHECK_EN adds AddrErrM and suppresses misaligned accesses.
module mem_access_stage
   import mips_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int REG_AW = DEF_REG_AW
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              RegWriteE,
   input  logic              MemtoRegE,
   input  logic              MemWriteE,
   input  logic              ValidE,
   input  logic [DATA_W-1:0] ALUOutE,
   input  logic [DATA_W-1:0] WriteDataE,
   input  logic [REG_AW-1:0] WriteRegE,
   output logic              StallM,
   output logic [DATA_W-1:0] ALUOutM,
   output logic [REG_AW-1:0] WriteRegM,
   output logic              RegWriteM,
   output logic              dreq_valid,
   input  logic              dreq_ready,
   output logic              dreq_we,
   output logic [DATA_W-1:0] dreq_addr,
   output logic [DATA_W-1:0] dreq_wdata,
   input  logic              dresp_valid,
   input  logic [DATA_W-1:0] dresp_rdata,
   output logic              RegWriteW,
   output logic              MemtoRegW,
   output logic [DATA_W-1:0] ALUOutW,
   output logic [DATA_W-1:0] ReadDataW,
   output logic [REG_AW-1:0] WriteRegW
`ifdef MEM_ALIGN_CHECK_EN
   ,
   output logic              AddrErrM
`endif
);

   mem_ctrl_t         ctrl_e, ctrl_m_q;
   logic [DATA_W-1:0] alu_m_q, wdata_m_q;
   logic [REG_AW-1:0] wreg_m_q;
   logic              mem_op, misalign, addr_err, load_done;

   assign ctrl_e = '{RegWrite: RegWriteE, MemtoReg: MemtoRegE,
                     MemWrite: MemWriteE, Valid: ValidE};

   // EX/MEM register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ctrl_m_q  <= '0;
         alu_m_q   <= '0;
         wdata_m_q <= '0;
         wreg_m_q  <= '0;
      end else if (!StallM) begin
         ctrl_m_q  <= ctrl_e;
         alu_m_q   <= ALUOutE;
         wdata_m_q <= WriteDataE;
         wreg_m_q  <= WriteRegE;
      end
   end

   assign mem_op = ctrl_m_q.Valid & (ctrl_m_q.MemtoReg | ctrl_m_q.MemWrite);

`ifdef MEM_ALIGN_CHECK_EN
   assign misalign = |alu_m_q[1:0];
   assign AddrErrM = addr_err;
`else
   assign misalign = 1'b0;
`endif
   assign addr_err = mem_op & misalign;

   assign ALUOutM    = alu_m_q;
   assign WriteRegM  = wreg_m_q;
   assign RegWriteM  = ctrl_m_q.Valid & ctrl_m_q.RegWrite;
   assign dreq_addr  = alu_m_q;
   assign dreq_wdata = wdata_m_q;
   assign dreq_we    = ctrl_m_q.MemWrite;

   mem_req_fsm u_fsm (
      .clk          (clk),
      .rst_n        (resetn),
      .mem_op_i     (mem_op & ~addr_err),
      .store_i      (ctrl_m_q.MemWrite),
      .dreq_ready_i (dreq_ready),
      .dresp_valid_i(dresp_valid),
      .dreq_valid_o (dreq_valid),
      .stall_o      (StallM),
      .load_done_o  (load_done)
   );

   // MEM/WB register: a stalled cycle emits a bubble, data fields hold
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         RegWriteW <= 1'b0;
         MemtoRegW <= 1'b0;
         ALUOutW   <= '0;
         ReadDataW <= '0;
         WriteRegW <= '0;
      end else begin
         if (StallM) begin
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
         end else begin
            RegWriteW <= ctrl_m_q.Valid & ctrl_m_q.RegWrite & ~ctrl_m_q.MemWrite & ~addr_err;
            MemtoRegW <= ctrl_m_q.Valid & ctrl_m_q.MemtoReg & ~addr_err;
            ALUOutW   <= alu_m_q;
            WriteRegW <= wreg_m_q;
         end
         if (load_done) ReadDataW <= dresp_rdata;
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: per-cycle comparison against a
// transaction-level model plus hand-computed checkpoints.
module tb_mem_access_stage;

`ifdef MEM_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic        clk, resetn;
   logic        RegWriteE, MemtoRegE, MemWriteE, ValidE;
   logic [31:0] ALUOutE, WriteDataE;
   logic [4:0]  WriteRegE;
   logic        StallM, RegWriteM, dreq_valid, dreq_ready, dreq_we, dresp_valid;
   logic [31:0] ALUOutM, dreq_addr, dreq_wdata, dresp_rdata, ALUOutW, ReadDataW;
   logic [4:0]  WriteRegM, WriteRegW;
   logic        RegWriteW, MemtoRegW;
`ifdef MEM_ALIGN_CHECK_EN
   logic        AddrErrM;
`endif

   mem_access_stage dut (
      .clk(clk), .resetn(resetn),
      .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .ValidE(ValidE),
      .ALUOutE(ALUOutE), .WriteDataE(WriteDataE), .WriteRegE(WriteRegE),
      .StallM(StallM), .ALUOutM(ALUOutM), .WriteRegM(WriteRegM), .RegWriteM(RegWriteM),
      .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_we(dreq_we),
      .dreq_addr(dreq_addr), .dreq_wdata(dreq_wdata),
      .dresp_valid(dresp_valid), .dresp_rdata(dresp_rdata),
      .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .ALUOutW(ALUOutW),
      .ReadDataW(ReadDataW), .WriteRegW(WriteRegW)
`ifdef MEM_ALIGN_CHECK_EN
      , .AddrErrM(AddrErrM)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic rw, mtr, mw, v;
      logic [31:0] alu, wd;
      logic [4:0] wr;
   } ins_t;

   ins_t        m;
   logic        acc, first, retire;
   logic        rwW, mtrW;
   logic [31:0] aluW, rdW;
   logic [4:0]  wrW;

   function automatic ins_t mk(input logic rw, mtr, mw, v, input logic [31:0] alu, wd,
                               input logic [4:0] wr);
      ins_t i;
      i = '{rw: rw, mtr: mtr, mw: mw, v: v, alu: alu, wd: wd, wr: wr};
      return i;
   endfunction

   function automatic logic is_mem(input ins_t i);
      return i.v & (i.mtr | i.mw);
   endfunction

   function automatic logic is_err(input ins_t i);
      return ALIGN && is_mem(i) && (i.alu[1:0] != 2'b00);
   endfunction

   // A store stalls unless accepted in its first M cycle (or it is in its
   // retirement cycle); a load stalls until its response arrives after acceptance.
   function automatic logic exp_stall();
      if (!is_mem(m) || is_err(m)) return 1'b0;
      if (m.mw) return retire ? 1'b0 : !(dreq_ready && first);
      return acc ? !dresp_valid : 1'b1;
   endfunction

   function automatic logic exp_dv();
      if (!is_mem(m) || is_err(m)) return 1'b0;
      if (m.mw) return !retire;
      return !acc;
   endfunction

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m <= '0; acc <= 1'b0; first <= 1'b1; retire <= 1'b0;
         rwW <= 1'b0; mtrW <= 1'b0; aluW <= '0; rdW <= '0; wrW <= '0;
      end else if (exp_stall()) begin
         rwW <= 1'b0; mtrW <= 1'b0; first <= 1'b0;
         if (exp_dv() && dreq_ready) begin
            if (m.mw) retire <= 1'b1;
            else      acc    <= 1'b1;
         end
      end else begin
         rwW  <= m.v & m.rw & ~m.mw & ~is_err(m);
         mtrW <= m.v & m.mtr & ~is_err(m);
         aluW <= m.alu;
         wrW  <= m.wr;
         if (is_mem(m) && !m.mw && acc && dresp_valid) rdW <= dresp_rdata;
         m <= mk(RegWriteE, MemtoRegE, MemWriteE, ValidE, ALUOutE, WriteDataE, WriteRegE);
         acc <= 1'b0; retire <= 1'b0; first <= 1'b1;
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (chk_en) begin
            chk("StallM",     StallM,     exp_stall());
            chk("dreq_valid", dreq_valid, exp_dv());
            chk("dreq_we",    dreq_we,    m.mw);
            chk("dreq_addr",  dreq_addr,  m.alu);
            chk("dreq_wdata", dreq_wdata, m.wd);
            chk("ALUOutM",    ALUOutM,    m.alu);
            chk("WriteRegM",  WriteRegM,  m.wr);
            chk("RegWriteM",  RegWriteM,  m.v & m.rw);
            chk("RegWriteW",  RegWriteW,  rwW);
            chk("MemtoRegW",  MemtoRegW,  mtrW);
            chk("ALUOutW",    ALUOutW,    aluW);
            chk("ReadDataW",  ReadDataW,  rdW);
            chk("WriteRegW",  WriteRegW,  wrW);
`ifdef MEM_ALIGN_CHECK_EN
            chk("AddrErrM",   AddrErrM,   is_err(m));
`endif
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc(input ins_t e, input logic rdy, input logic rv, input logic [31:0] rd);
      @(negedge clk);
      RegWriteE  = e.rw;  MemtoRegE = e.mtr; MemWriteE = e.mw; ValidE = e.v;
      ALUOutE    = e.alu; WriteDataE = e.wd; WriteRegE = e.wr;
      dreq_ready = rdy;   dresp_valid = rv;  dresp_rdata = rd;
   endtask

   ins_t NOP;

   initial begin
      NOP = '0;
      resetn = 1'b0;
      RegWriteE = 0; MemtoRegE = 0; MemWriteE = 0; ValidE = 0;
      ALUOutE = '0; WriteDataE = '0; WriteRegE = '0;
      dreq_ready = 0; dresp_valid = 0; dresp_rdata = '0;
      chk_en = 1'b1;

      // reset state
      cyc(NOP, 1, 1, 32'h1111_2222);
      #3;
      chk("rst_StallM", StallM, 0);
      chk("rst_dreq_valid", dreq_valid, 0);
      chk("rst_RegWriteW", RegWriteW, 0);
      chk("rst_ReadDataW", ReadDataW, 0);
      cyc(NOP, 0, 0, 0);
      resetn = 1'b1;

      // load 0x100, accepted immediately, response next cycle
      cyc(mk(1, 1, 0, 1, 32'h100, 32'h0, 5'd3), 0, 0, 0);
      cyc(NOP, 1, 0, 0);
      #3;
      chk("ld_stall_c1", StallM, 1);
      chk("ld_dv_c1", dreq_valid, 1);
      cyc(NOP, 0, 1, 32'hDEAD_BEEF);
      #3;
      chk("ld_stall_c2", StallM, 0);
      cyc(NOP, 0, 0, 0);
      #3;
      chk("ld_RegWriteW", RegWriteW, 1);
      chk("ld_MemtoRegW", MemtoRegW, 1);
      chk("ld_ReadDataW", ReadDataW, 32'hDEAD_BEEF);
      chk("ld_WriteRegW", WriteRegW, 3);

      // store to 0x200, accepted immediately
      cyc(mk(0, 0, 1, 1, 32'h200, 32'h55, 5'd0), 0, 0, 0);
      cyc(NOP, 1, 0, 0);
      #3;
      chk("st_we", dreq_we, 1);
      chk("st_wdata", dreq_wdata, 32'h55);
      chk("st_stall", StallM, 0);
      cyc(NOP, 0, 0, 0);
      #3;
      chk("st_RegWriteW", RegWriteW, 0);

      // load with ready low for 3 cycles
      cyc(mk(1, 1, 0, 1, 32'h300, 32'h0, 5'd7), 0, 0, 0);
      cyc(NOP, 0, 0, 0);
      cyc(NOP, 0, 0, 0);
      #3;
      chk("ldw_stall", StallM, 1);
      chk("ldw_addr", dreq_addr, 32'h300);
      chk("ldw_bubble", RegWriteW, 0);
      cyc(NOP, 0, 0, 0);
      cyc(NOP, 1, 0, 0);
      cyc(NOP, 0, 1, 32'h1234_5678);
      cyc(NOP, 0, 0, 0);
      #3;
      chk("ldw_ReadDataW", ReadDataW, 32'h1234_5678);

      // store via REQ, then a back-to-back store issued from IDLE
      cyc(mk(0, 0, 1, 1, 32'h400, 32'hA, 5'd0), 0, 0, 0);
      cyc(mk(1, 0, 1, 1, 32'h404, 32'hB, 5'd2), 0, 0, 0);
      cyc(mk(1, 0, 1, 1, 32'h404, 32'hB, 5'd2), 1, 0, 0);
      #3;
      chk("st2_accept_stall", StallM, 1);
      cyc(mk(1, 0, 1, 1, 32'h404, 32'hB, 5'd2), 0, 0, 0);
      #3;
      chk("st2_retire_dv", dreq_valid, 0);
      chk("st2_retire_stall", StallM, 0);
      cyc(NOP, 1, 0, 0);
      #3;
      chk("st2_b_addr", dreq_addr, 32'h404);
      chk("st2_b_stall", StallM, 0);
      cyc(NOP, 0, 0, 0);
      #3;
      chk("st2_b_RegWriteW", RegWriteW, 0);

      // invalid slot with mem bits, ALU op, then a load
      cyc(mk(1, 0, 1, 0, 32'h700, 32'h7, 5'd1), 0, 0, 0);
      cyc(mk(1, 0, 0, 1, 32'h77, 32'h0, 5'd9), 1, 0, 0);
      #3;
      chk("bub_dv", dreq_valid, 0);
      chk("bub_RegWriteM", RegWriteM, 0);
      cyc(mk(1, 1, 0, 1, 32'h500, 32'h0, 5'd10), 1, 0, 0);
      #3;
      chk("alu_dv", dreq_valid, 0);
      chk("alu_RegWriteM", RegWriteM, 1);
      cyc(NOP, 1, 0, 0);
      #3;
      chk("alu_RegWriteW", RegWriteW, 1);
      chk("alu_ALUOutW", ALUOutW, 32'h77);
      chk("alu_WriteRegW", WriteRegW, 9);
      cyc(NOP, 0, 1, 32'hCAFE_F00D);
      cyc(NOP, 0, 0, 0);
      #3;
      chk("alu_ld_ReadDataW", ReadDataW, 32'hCAFE_F00D);

      // reset while waiting for a load response, late response afterwards
      cyc(mk(1, 1, 0, 1, 32'h600, 32'h0, 5'd4), 0, 0, 0);
      cyc(NOP, 1, 0, 0);
      cyc(NOP, 0, 0, 0);
      #4 resetn = 1'b0;
      cyc(NOP, 0, 0, 0);
      #3;
      chk("rstw_StallM", StallM, 0);
      chk("rstw_ALUOutM", ALUOutM, 0);
      chk("rstw_ReadDataW", ReadDataW, 0);
      cyc(NOP, 0, 1, 32'h0000_0BAD);
      resetn = 1'b1;
      cyc(NOP, 0, 0, 0);
      #3;
      chk("late_ReadDataW", ReadDataW, 0);
      chk("late_RegWriteW", RegWriteW, 0);
      chk("late_StallM", StallM, 0);

      // load at misaligned 0x102
      cyc(mk(1, 1, 0, 1, 32'h102, 32'h0, 5'd5), 0, 0, 0);
      cyc(NOP, 1, 0, 0);
      #3;
      chk("mis_dv", dreq_valid, ALIGN ? 1'b0 : 1'b1);
      chk("mis_stall", StallM, ALIGN ? 1'b0 : 1'b1);
`ifdef MEM_ALIGN_CHECK_EN
      chk("mis_AddrErrM", AddrErrM, 1);
`endif
      cyc(NOP, 0, 1, 32'h0BAD_CAFE);
      cyc(NOP, 0, 0, 0);
      #3;
      chk("mis_RegWriteW", RegWriteW, ALIGN ? 1'b0 : 1'b1);
`ifdef MEM_ALIGN_CHECK_EN
      chk("mis_AddrErrM_off", AddrErrM, 0);
`endif
      cyc(NOP, 0, 0, 0);
      cyc(NOP, 0, 0, 0);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
